// File: rtl/brick_scheduler.sv
// ---------------------------------------------------------------------------
// brick_scheduler
//
// Purpose:
//   Walks the 16 x 4 brick grid once per start request. For each slot it reads
//   the health from brick memory, works out the brick's pixel origin and hands
//   it to the brick drawer. It also owns the single brick-memory port, so it
//   interleaves game-logic hit requests (read, decrement, write back) into the
//   gaps between bricks and into idle time. Scan reads and hit writes can then
//   never collide on the port.
//
// Ports:
//   clk, resetn              clock; synchronous active-low reset
//   start                    one-cycle request for a full scan
//   busy, done               status: busy outside IDLE, done pulse at scan end
//   mem_addr, mem_health     memory address and read data (one-cycle latency)
//   mem_wren, mem_wdata      memory write strobe and write data
//   hit_req, hit_addr        held hit request and the slot it targets
//   hit_ack                  one-cycle pulse that completes a hit
//   draw_go                  one-cycle launch pulse for the drawer
//   draw_x, draw_y           brick origin, held from one GO to the next
//   draw_health              health captured for the brick being drawn
//   draw_done                drawer completion, only honoured in WAIT_DRAW
// ---------------------------------------------------------------------------
module brick_scheduler #(
    parameter int BRICK_W      = 10,
    parameter int BRICK_H      = 4,
    parameter int X0           = 0,
    parameter int Y0           = 8,
    parameter int DRAW_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [5:0] mem_addr,
    input  logic [1:0] mem_health,
    output logic       mem_wren,
    output logic [1:0] mem_wdata,
    input  logic       hit_req,
    input  logic [5:0] hit_addr,
    output logic       hit_ack,
    output logic       draw_go,
    output logic [9:0] draw_x,
    output logic [9:0] draw_y,
    output logic [1:0] draw_health,
    input  logic       draw_done
);

    typedef enum logic [3:0] {
        IDLE,
        HIT_RD,
        HIT_WAIT,
        HIT_WR,
        RD,
        RD_WAIT,
        GO,
        WAIT_DRAW,
        NEXT,
        DONE
    } state_t;

    // The dwell counter only has to reach DRAW_TIMEOUT-1.
    localparam int CNT_W = (DRAW_TIMEOUT > 2) ? $clog2(DRAW_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_TIMEOUT - 1);
    localparam logic [5:0] LAST_IDX = 6'd63;

    state_t           state_q, state_d;
    logic [5:0]       idx_q, idx_d;
    logic             pend_start_q, pend_start_d;
    logic             ret_scan_q, ret_scan_d;
    logic [1:0]       hreg_q, hreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       draw_x_q, draw_x_d;
    logic [9:0]       draw_y_q, draw_y_d;
    logic [1:0]       draw_health_q, draw_health_d;

    logic [9:0]       x_calc;
    logic [9:0]       y_calc;

    // Brick origin from the grid position: the low nibble of idx is the
    // column and the top two bits are the row. The sums wrap at 10 bits.
    always_comb begin
        x_calc = 10'(X0) + 10'(BRICK_W) * 10'(idx_q[3:0]);
        y_calc = 10'(Y0) + 10'(BRICK_H) * 10'(idx_q[5:4]);
    end

    // State register and data registers. Reset abandons any operation in
    // flight; because every strobe is decoded from the state, returning to
    // IDLE guarantees that no write is issued.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            idx_q         <= 6'd0;
            pend_start_q  <= 1'b0;
            ret_scan_q    <= 1'b0;
            hreg_q        <= 2'd0;
            cnt_q         <= '0;
            draw_x_q      <= 10'd0;
            draw_y_q      <= 10'd0;
            draw_health_q <= 2'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pend_start_q  <= pend_start_d;
            ret_scan_q    <= ret_scan_d;
            hreg_q        <= hreg_d;
            cnt_q         <= cnt_d;
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            draw_health_q <= draw_health_d;
        end
    end

    // Next-state and data-path logic.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pend_start_d  = pend_start_q;
        ret_scan_d    = ret_scan_q;
        hreg_d        = hreg_q;
        cnt_d         = cnt_q;
        draw_x_d      = draw_x_q;
        draw_y_d      = draw_y_q;
        draw_health_d = draw_health_q;

        // Starts are latched here so that a start arriving while a hit or a
        // scan is running is not lost. A start during DONE would just repeat
        // the scan that is finishing, so it is dropped. When IDLE consumes the
        // pending flag below, that clear takes precedence, which merges a
        // start seen in the same cycle into the scan that is launching.
        if (start && (state_q != DONE)) begin
            pend_start_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hit_req) begin
                    state_d    = HIT_RD;
                    ret_scan_d = 1'b0;
                end else if (pend_start_q) begin
                    state_d      = RD;
                    idx_d        = 6'd0;
                    pend_start_d = 1'b0;
                end
            end
            HIT_RD: begin
                state_d = HIT_WAIT;
            end
            HIT_WAIT: begin
                hreg_d  = mem_health;
                state_d = HIT_WR;
            end
            HIT_WR: begin
                state_d    = ret_scan_q ? RD : IDLE;
                ret_scan_d = 1'b0;
            end
            RD: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                draw_health_d = mem_health;
                draw_x_d      = x_calc;
                draw_y_d      = y_calc;
                state_d       = GO;
            end
            GO: begin
                cnt_d   = '0;
                state_d = WAIT_DRAW;
            end
            WAIT_DRAW: begin
                cnt_d = cnt_q + 1'b1;
                if (draw_done || (cnt_q == CNT_LAST)) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                // The gap between two bricks is the only place a hit may be
                // inserted during a scan, so at most one hit fits per gap.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                    if (hit_req) begin
                        state_d    = HIT_RD;
                        ret_scan_d = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            DONE: begin
                idx_d   = 6'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = 1'b0;
        mem_addr  = 6'd0;
        mem_wren  = 1'b0;
        mem_wdata = 2'd0;
        hit_ack   = 1'b0;
        draw_go   = 1'b0;

        case (state_q)
            HIT_RD, HIT_WAIT: begin
                mem_addr = hit_addr;
            end
            HIT_WR: begin
                // Health saturates at zero: a hit on a dead brick is
                // acknowledged but writes nothing.
                hit_ack   = 1'b1;
                mem_addr  = hit_addr;
                mem_wren  = (hreg_q != 2'd0);
                mem_wdata = (hreg_q != 2'd0) ? (hreg_q - 2'd1) : 2'd0;
            end
            RD, RD_WAIT: begin
                mem_addr = idx_q;
            end
            GO: begin
                draw_go = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign draw_x      = draw_x_q;
    assign draw_y      = draw_y_q;
    assign draw_health = draw_health_q;

endmodule

// File: tb/tb_brick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_brick_scheduler
//
// Directed bench for brick_scheduler. A behavioural synchronous RAM stands in
// for brick memory, and a drawer model can answer each draw_go with draw_done
// one cycle later. A negedge monitor records every draw_go (origin, health,
// cycle) together with done/busy/write activity for the scenario tasks.
// ---------------------------------------------------------------------------
module tb_brick_scheduler;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       busy;
    logic       done;
    logic [5:0] mem_addr;
    logic [1:0] mem_health;
    logic       mem_wren;
    logic [1:0] mem_wdata;
    logic       hit_req;
    logic [5:0] hit_addr;
    logic       hit_ack;
    logic       draw_go;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic [1:0] draw_health;
    logic       draw_done;

    int n_cmp = 0;
    int n_fail = 0;

    // Memory model with a bench-side preload port.
    logic [1:0] ram [64];
    logic       pre_en;
    logic [5:0] pre_addr;
    logic [1:0] pre_data;

    // Drawer model controls.
    logic auto_en;
    logic manual_done;

    // Monitor bookkeeping.
    logic [9:0] rec_x [1024];
    logic [9:0] rec_y [1024];
    logic [1:0] rec_h [1024];
    int         rec_cyc [1024];
    int         go_cnt = 0;
    int         done_cnt = 0;
    int         wren_cnt = 0;
    int         cyc = 0;
    int         done_cyc = 0;
    int         rise_cyc = 0;
    logic       prev_go;
    logic       prev_busy;

    brick_scheduler dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_health  (mem_health),
        .mem_wren    (mem_wren),
        .mem_wdata   (mem_wdata),
        .hit_req     (hit_req),
        .hit_addr    (hit_addr),
        .hit_ack     (hit_ack),
        .draw_go     (draw_go),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_health (draw_health),
        .draw_done   (draw_done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_wren) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_health <= ram[mem_addr];
    end

    // Drawer model and activity monitor, sampled on the falling edge.
    initial begin
        draw_done = 1'b0;
        prev_go   = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            draw_done = (auto_en && prev_go) || manual_done;
            prev_go   = draw_go;
            if (draw_go === 1'b1 && go_cnt < 1024) begin
                rec_x[go_cnt]   = draw_x;
                rec_y[go_cnt]   = draw_y;
                rec_h[go_cnt]   = draw_health;
                rec_cyc[go_cnt] = cyc;
                go_cnt++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_wren === 1'b1) wren_cnt++;
            if (busy === 1'b1 && prev_busy !== 1'b1) rise_cyc = cyc;
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic preload(input logic [5:0] a, input logic [1:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick(1);
        pre_en   = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(2);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0d, expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %0d, expected 0", done); end
        n_cmp++; if (mem_addr !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %0d, expected 0", mem_addr); end
        n_cmp++; if (mem_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_wren: got %0d, expected 0", mem_wren); end
        n_cmp++; if (hit_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hit_ack: got %0d, expected 0", hit_ack); end
        n_cmp++; if (draw_go !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_draw_go: got %0d, expected 0", draw_go); end
        n_cmp++; if (draw_x !== 10'd0 || draw_y !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_draw_xy: got %0d/%0d, expected 0/0", draw_x, draw_y); end
        n_cmp++; if (draw_health !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_draw_health: got %0d, expected 0", draw_health); end
        resetn = 1'b1;
        tick(1);
        for (int i = 0; i < 64; i++) preload(6'(i), 2'd3);
    endtask

    task automatic test_hit_then_scan();
        int b, d0;
        preload(6'd5, 2'd2);
        auto_en = 1'b1;
        b  = go_cnt;
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 2000 && done_cnt == d0; i++) tick(1);
        n_cmp++; if (done_cnt != d0 + 1) begin n_fail++; $display("[TB] FAIL scan1_done_count: got %0d, expected %0d", done_cnt - d0, 1); end
        n_cmp++; if (go_cnt - b != 64) begin n_fail++; $display("[TB] FAIL scan1_go_count: got %0d, expected 64", go_cnt - b); end
        n_cmp++; if (rec_x[b+5] !== 10'd50 || rec_y[b+5] !== 10'd8) begin n_fail++; $display("[TB] FAIL scan1_brick5_xy: got %0d/%0d, expected 50/8", rec_x[b+5], rec_y[b+5]); end
        n_cmp++; if (rec_h[b+5] !== 2'd2) begin n_fail++; $display("[TB] FAIL scan1_brick5_health: got %0d, expected 2", rec_h[b+5]); end
        n_cmp++; if (rec_x[b] !== 10'd0 || rec_y[b] !== 10'd8 || rec_h[b] !== 2'd3) begin n_fail++; $display("[TB] FAIL scan1_brick0: got %0d/%0d/%0d, expected 0/8/3", rec_x[b], rec_y[b], rec_h[b]); end
        n_cmp++; if (rec_x[b+63] !== 10'd150 || rec_y[b+63] !== 10'd20) begin n_fail++; $display("[TB] FAIL scan1_brick63_xy: got %0d/%0d, expected 150/20", rec_x[b+63], rec_y[b+63]); end
        n_cmp++; if (done_cyc - rise_cyc != 320) begin n_fail++; $display("[TB] FAIL scan1_length: got %0d, expected 321 cycles", done_cyc - rise_cyc + 1); end
        n_cmp++; if (rec_cyc[b+1] - rec_cyc[b] != 5) begin n_fail++; $display("[TB] FAIL scan1_brick_period: got %0d, expected 5", rec_cyc[b+1] - rec_cyc[b]); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL scan1_idle_after: got busy %0d, expected 0", busy); end
    endtask

    task automatic test_hit_idle();
        int b, d0, w0;
        w0 = wren_cnt;
        hit_addr = 6'd17;
        hit_req  = 1'b1;
        tick(1);
        n_cmp++; if (busy !== 1'b1 || mem_addr !== 6'd17) begin n_fail++; $display("[TB] FAIL hit_rd: got busy %0d addr %0d, expected 1 17", busy, mem_addr); end
        tick(1);
        n_cmp++; if (hit_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_early_ack: got %0d, expected 0", hit_ack); end
        tick(1);
        n_cmp++; if (hit_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL hit_ack_t3: got %0d, expected 1", hit_ack); end
        n_cmp++; if (mem_wren !== 1'b1 || mem_wdata !== 2'd2 || mem_addr !== 6'd17) begin n_fail++; $display("[TB] FAIL hit_write: got wren %0d data %0d addr %0d, expected 1 2 17", mem_wren, mem_wdata, mem_addr); end
        hit_req = 1'b0;
        tick(1);
        n_cmp++; if (busy !== 1'b0 || hit_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_return_idle: got busy %0d ack %0d, expected 0 0", busy, hit_ack); end
        n_cmp++; if (ram[17] !== 2'd2) begin n_fail++; $display("[TB] FAIL hit_ram17: got %0d, expected 2", ram[17]); end
        n_cmp++; if (wren_cnt - w0 != 1) begin n_fail++; $display("[TB] FAIL hit_write_count: got %0d, expected 1", wren_cnt - w0); end
        b  = go_cnt;
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 2000 && done_cnt == d0; i++) tick(1);
        n_cmp++; if (done_cnt == d0) begin n_fail++; $display("[TB] FAIL hit_scan_done: got %0d, expected 1", done_cnt - d0); end
        n_cmp++; if (rec_h[b+17] !== 2'd2 || rec_x[b+17] !== 10'd10 || rec_y[b+17] !== 10'd12) begin n_fail++; $display("[TB] FAIL hit_scan_brick17: got %0d/%0d/%0d, expected 10/12/2", rec_x[b+17], rec_y[b+17], rec_h[b+17]); end
    endtask

    task automatic test_saturation();
        int w0;
        preload(6'd0, 2'd0);
        w0 = wren_cnt;
        hit_addr = 6'd0;
        hit_req  = 1'b1;
        tick(3);
        n_cmp++; if (hit_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_ack: got %0d, expected 1", hit_ack); end
        n_cmp++; if (mem_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_wren: got %0d, expected 0", mem_wren); end
        hit_req = 1'b0;
        tick(1);
        n_cmp++; if (ram[0] !== 2'd0 || wren_cnt != w0) begin n_fail++; $display("[TB] FAIL sat_ram0: got %0d (writes %0d), expected 0 (0)", ram[0], wren_cnt - w0); end
    endtask

    task automatic test_mid_scan_hit();
        int b, d0, acked;
        // Part 1: hit on a brick further along the scan.
        preload(6'd63, 2'd1);
        b = go_cnt; d0 = done_cnt; acked = -1;
        pulse_start();
        for (int i = 0; i < 200 && go_cnt < b + 11; i++) tick(1);
        hit_addr = 6'd63;
        hit_req  = 1'b1;
        for (int i = 0; i < 20 && hit_ack !== 1'b1; i++) tick(1);
        if (hit_ack === 1'b1) acked = go_cnt - b;
        hit_req = 1'b0;
        n_cmp++; if (acked != 11) begin n_fail++; $display("[TB] FAIL mid1_ack_position: got %0d bricks drawn, expected 11", acked); end
        for (int i = 0; i < 2000 && done_cnt == d0; i++) tick(1);
        n_cmp++; if (go_cnt - b != 64) begin n_fail++; $display("[TB] FAIL mid1_go_count: got %0d, expected 64", go_cnt - b); end
        n_cmp++; if (rec_h[b+63] !== 2'd0) begin n_fail++; $display("[TB] FAIL mid1_brick63_health: got %0d, expected 0", rec_h[b+63]); end
        n_cmp++; if (rec_x[b+11] !== 10'd110 || rec_h[b+11] !== 2'd3) begin n_fail++; $display("[TB] FAIL mid1_brick11: got x %0d h %0d, expected 110 3", rec_x[b+11], rec_h[b+11]); end
        n_cmp++; if (rec_cyc[b+11] - rec_cyc[b+10] != 8) begin n_fail++; $display("[TB] FAIL mid1_gap: got %0d, expected 8", rec_cyc[b+11] - rec_cyc[b+10]); end

        // Part 2: hit on a brick that has already been drawn.
        preload(6'd3, 2'd1);
        b = go_cnt; d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 200 && go_cnt < b + 11; i++) tick(1);
        hit_addr = 6'd3;
        hit_req  = 1'b1;
        for (int i = 0; i < 20 && hit_ack !== 1'b1; i++) tick(1);
        hit_req = 1'b0;
        for (int i = 0; i < 2000 && done_cnt == d0; i++) tick(1);
        n_cmp++; if (rec_h[b+3] !== 2'd1) begin n_fail++; $display("[TB] FAIL mid2_brick3_this_scan: got %0d, expected 1", rec_h[b+3]); end
        n_cmp++; if (ram[3] !== 2'd0) begin n_fail++; $display("[TB] FAIL mid2_ram3: got %0d, expected 0", ram[3]); end
        b = go_cnt; d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 2000 && done_cnt == d0; i++) tick(1);
        n_cmp++; if (rec_h[b+3] !== 2'd0) begin n_fail++; $display("[TB] FAIL mid2_brick3_next_scan: got %0d, expected 0", rec_h[b+3]); end
    endtask

    task automatic test_timeout_merge();
        int b, d0;
        auto_en = 1'b0;
        b = go_cnt; d0 = done_cnt;
        pulse_start();
        tick(100);
        pulse_start();
        tick(300);
        pulse_start();
        for (int i = 0; i < 3000 && done_cnt == d0; i++) tick(1);
        n_cmp++; if (done_cnt != d0 + 1) begin n_fail++; $display("[TB] FAIL to_scan1_done: got %0d, expected 1", done_cnt - d0); end
        n_cmp++; if (done_cyc - rise_cyc != 1280) begin n_fail++; $display("[TB] FAIL to_scan1_length: got %0d, expected 1281 cycles", done_cyc - rise_cyc + 1); end
        n_cmp++; if (rec_cyc[b+1] - rec_cyc[b] != 20) begin n_fail++; $display("[TB] FAIL to_brick_period: got %0d, expected 20", rec_cyc[b+1] - rec_cyc[b]); end
        n_cmp++; if (go_cnt - b != 64) begin n_fail++; $display("[TB] FAIL to_scan1_go_count: got %0d, expected 64", go_cnt - b); end

        // The two merged starts give exactly one further scan; a start
        // landing in its DONE cycle is dropped.
        b = go_cnt;
        for (int i = 0; i < 3000 && done !== 1'b1; i++) tick(1);
        pulse_start();
        n_cmp++; if (go_cnt - b != 64) begin n_fail++; $display("[TB] FAIL to_scan2_go_count: got %0d, expected 64", go_cnt - b); end
        n_cmp++; if (done_cnt != d0 + 2) begin n_fail++; $display("[TB] FAIL to_scan2_done: got %0d, expected 2", done_cnt - d0); end
        n_cmp++; if (done_cyc - rise_cyc != 1280) begin n_fail++; $display("[TB] FAIL to_scan2_length: got %0d, expected 1281 cycles", done_cyc - rise_cyc + 1); end
        b = go_cnt;
        tick(6);
        n_cmp++; if (busy !== 1'b0 || go_cnt != b) begin n_fail++; $display("[TB] FAIL to_start_in_done: got busy %0d gos %0d, expected 0 0", busy, go_cnt - b); end

        // A stray draw_done while idle changes nothing.
        manual_done = 1'b1;
        tick(1);
        manual_done = 1'b0;
        tick(4);
        n_cmp++; if (busy !== 1'b0 || go_cnt != b || draw_go !== 1'b0) begin n_fail++; $display("[TB] FAIL stale_draw_done: got busy %0d gos %0d, expected 0 0", busy, go_cnt - b); end
    endtask

    task automatic test_reset_mid();
        int b, d0, w0;
        auto_en = 1'b1;
        b = go_cnt;
        pulse_start();
        for (int i = 0; i < 400 && go_cnt < b + 31; i++) tick(1);
        w0 = wren_cnt;
        resetn = 1'b0;
        tick(1);
        n_cmp++; if (busy !== 1'b0 || mem_addr !== 6'd0 || draw_go !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_scan_ctrl: got busy %0d addr %0d go %0d done %0d, expected 0", busy, mem_addr, draw_go, done); end
        n_cmp++; if (draw_x !== 10'd0 || draw_y !== 10'd0 || draw_health !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_scan_draw: got %0d/%0d/%0d, expected 0/0/0", draw_x, draw_y, draw_health); end
        resetn = 1'b1;
        tick(2);

        hit_addr = 6'd9;
        hit_req  = 1'b1;
        tick(2);
        resetn  = 1'b0;
        hit_req = 1'b0;
        tick(1);
        n_cmp++; if (busy !== 1'b0 || hit_ack !== 1'b0 || mem_wren !== 1'b0 || mem_addr !== 6'd0) begin n_fail++; $display("[TB] FAIL rst_hit_outputs: got busy %0d ack %0d wren %0d addr %0d, expected 0", busy, hit_ack, mem_wren, mem_addr); end
        resetn = 1'b1;
        tick(3);
        n_cmp++; if (ram[9] !== 2'd3 || wren_cnt != w0) begin n_fail++; $display("[TB] FAIL rst_no_write: got ram9 %0d writes %0d, expected 3 0", ram[9], wren_cnt - w0); end

        b = go_cnt; d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 50 && go_cnt == b; i++) tick(1);
        n_cmp++; if (go_cnt == b || rec_x[b] !== 10'd0 || rec_y[b] !== 10'd8 || rec_h[b] !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_restart_idx0: got %0d/%0d/%0d, expected 0/8/0", rec_x[b], rec_y[b], rec_h[b]); end
        for (int i = 0; i < 2000 && done_cnt == d0; i++) tick(1);
        n_cmp++; if (go_cnt - b != 64) begin n_fail++; $display("[TB] FAIL rst_restart_go_count: got %0d, expected 64", go_cnt - b); end
    endtask

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        hit_req     = 1'b0;
        hit_addr    = 6'd0;
        pre_en      = 1'b0;
        pre_addr    = 6'd0;
        pre_data    = 2'd0;
        auto_en     = 1'b0;
        manual_done = 1'b0;
        $display("[TB] brick_scheduler bench starting");
        test_reset();
        test_hit_then_scan();
        test_hit_idle();
        test_saturation();
        test_mid_scan_hit();
        test_timeout_merge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
